// File: rtl/password_checker_pkg.sv
// Shared types and constants for the password checker block.
package password_checker_pkg;
  typedef enum logic [2:0] {
    IDLE, CHECKLEN, REQUEST, CAPTURE, COMPARE, FOUND, FAIL
  } state_t;

  localparam logic [7:0] ASCII_A       = 8'h61;
  localparam logic [7:0] ASCII_Z       = 8'h7A;
  localparam int         PWD_BYTES_MAX = 16;
  localparam int         BITS_PER_CHAR = 8;

  // Length is in bits: non-zero, whole bytes, within the bus.
  function automatic logic len_legal(input logic [7:0] len, input int max_bytes);
    return (len != 8'd0) && ({1'b0, len} <= 9'(max_bytes * BITS_PER_CHAR)) && (len[2:0] == 3'd0);
  endfunction
endpackage

// File: rtl/password_checker_byte_group_compare.sv
// Compares one group of BYTES_PER_CYCLE bytes at a registered byte index,
// masking bytes beyond the password length.
module byte_group_compare
  import password_checker_pkg::*;
#(
  parameter int PWD_BYTES       = 16,
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clr_i,
  input  logic                             adv_i,
  input  logic [BITS_PER_CHAR*PWD_BYTES-1:0] cand_i,
  input  logic [BITS_PER_CHAR*PWD_BYTES-1:0] tgt_i,
  input  logic [4:0]                       nbytes_i,
  output logic                             group_equal_o,
  output logic                             last_group_o
);
  // One spare bit so idx + BYTES_PER_CYCLE never wraps.
  localparam int IW = $clog2(PWD_BYTES) + 2;

  logic [IW-1:0] idx_q, idx_d, hi, nbytes;

  assign nbytes = IW'(nbytes_i);
  assign hi     = idx_q + IW'(BYTES_PER_CYCLE);

  always_comb begin
    group_equal_o = 1'b1;
    for (int b = 0; b < PWD_BYTES; b++) begin
      if (IW'(b) >= idx_q && IW'(b) < hi && IW'(b) < nbytes &&
          cand_i[b*BITS_PER_CHAR +: BITS_PER_CHAR] != tgt_i[b*BITS_PER_CHAR +: BITS_PER_CHAR])
        group_equal_o = 1'b0;
    end
    last_group_o = (hi >= nbytes);
    idx_d = idx_q;
    if (clr_i)      idx_d = '0;
    else if (adv_i) idx_d = hi;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end
endmodule

// File: rtl/password_checker.sv
// Password checker: pulls candidates from the generator and compares them byte-serially.
// Optional ATTEMPT_LIMIT_EN adds maxAttempts to bound the search.
module password_checker
  import password_checker_pkg::*;
#(
  parameter int PWD_BYTES       = 16,
  parameter int BYTES_PER_CYCLE = 1,
  parameter int ATTEMPT_W       = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [BITS_PER_CHAR*PWD_BYTES-1:0] targetPassword,
  input  logic [7:0]                       targetLength,
  input  logic [BITS_PER_CHAR*PWD_BYTES-1:0] candidate,
  input  logic [7:0]                       candidateLength,
`ifdef ATTEMPT_LIMIT_EN
  input  logic [ATTEMPT_W-1:0]             maxAttempts,
`endif
  output logic                             enable,
  output logic                             ready,
  output logic                             busy,
  output logic                             done,
  output logic                             found,
  output logic                             lengthError,
  output logic [BITS_PER_CHAR*PWD_BYTES-1:0] matchPassword,
  output logic [ATTEMPT_W-1:0]             attempts
);
  localparam int BW = BITS_PER_CHAR * PWD_BYTES;

  state_t         state_q, state_d;
  logic [BW-1:0]  tgt_q, tgt_d, cand_q, cand_d, match_q, match_d;
  logic [7:0]     tlen_q, tlen_d, clen_q, clen_d;
  logic [ATTEMPT_W-1:0] att_q, att_d;
  logic           found_q, found_d, lerr_q, lerr_d, done_q, done_d;
  logic           geq, last, limit_hit;

  byte_group_compare #(.PWD_BYTES(PWD_BYTES), .BYTES_PER_CYCLE(BYTES_PER_CYCLE)) u_cmp (
    .clock(clock), .reset(reset),
    .clr_i(state_q == CAPTURE),
    .adv_i(state_q == COMPARE && geq && !last),
    .cand_i(cand_q), .tgt_i(tgt_q), .nbytes_i(tlen_q[7:3]),
    .group_equal_o(geq), .last_group_o(last)
  );

`ifdef ATTEMPT_LIMIT_EN
  assign limit_hit = (maxAttempts != '0) && (att_q == maxAttempts);
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q; tgt_d = tgt_q; tlen_d = tlen_q; cand_d = cand_q; clen_d = clen_q;
    att_d = att_q; found_d = found_q; lerr_d = lerr_q; match_d = match_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, FOUND, FAIL: if (start) begin
          tgt_d = targetPassword; tlen_d = targetLength;
          found_d = 1'b0; lerr_d = 1'b0; match_d = '0; att_d = '0;
          state_d = CHECKLEN;
        end
        CHECKLEN: if (!len_legal(tlen_q, PWD_BYTES)) begin
          lerr_d = 1'b1; state_d = FAIL;
        end else state_d = REQUEST;
        REQUEST: state_d = CAPTURE;
        CAPTURE: begin
          cand_d = candidate; clen_d = candidateLength;
          if (att_q != '1) att_d = att_q + 1'b1;
          state_d = COMPARE;
        end
        COMPARE: if (clen_q != tlen_q || !geq) begin
          state_d = limit_hit ? FAIL : REQUEST;
        end else if (last) begin
          found_d = 1'b1; match_d = cand_q; state_d = FOUND;
        end
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == FOUND || state_d == FAIL) && (state_d != state_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE; tgt_q <= '0; tlen_q <= '0; cand_q <= '0; clen_q <= '0;
      att_q <= '0; found_q <= 1'b0; lerr_q <= 1'b0; match_q <= '0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; tgt_q <= tgt_d; tlen_q <= tlen_d; cand_q <= cand_d; clen_q <= clen_d;
      att_q <= att_d; found_q <= found_d; lerr_q <= lerr_d; match_q <= match_d; done_q <= done_d;
    end
  end

  assign enable        = (state_q == CHECKLEN) || (state_q == REQUEST) ||
                         (state_q == CAPTURE)  || (state_q == COMPARE);
  assign ready         = (state_q == REQUEST);
  assign busy          = (state_q == REQUEST) || (state_q == CAPTURE) || (state_q == COMPARE);
  assign done          = done_q;
  assign found         = found_q;
  assign lengthError   = lerr_q;
  assign matchPassword = match_q;
  assign attempts      = att_q;
endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker with a brute-force generator model ("a".."z", then "aa"..).
module tb_password_checker;
  import password_checker_pkg::*;

  logic         clock = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [127:0] targetPassword = '0, candidate;
  logic [7:0]   targetLength = '0, candidateLength;
`ifdef ATTEMPT_LIMIT_EN
  logic [31:0]  maxAttempts = '0;
`endif
  logic         enable, ready, busy, done, found, lengthError;
  logic [127:0] matchPassword;
  logic [31:0]  attempts;

  int nchk = 0, nfail = 0;
  int gen_n = 0;
  bit gen_rst = 1'b0;
  int done_cnt = 0, rdy_cnt = 0, rdy_wide = 0;
  bit rdy_prev = 1'b0;

  password_checker dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .targetPassword(targetPassword), .targetLength(targetLength),
    .candidate(candidate), .candidateLength(candidateLength),
`ifdef ATTEMPT_LIMIT_EN
    .maxAttempts(maxAttempts),
`endif
    .enable(enable), .ready(ready), .busy(busy), .done(done), .found(found),
    .lengthError(lengthError), .matchPassword(matchPassword), .attempts(attempts)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] gen_word(input int n);
    int m;
    if (n <= 0)  return '0;
    if (n <= 26) return 128'(8'(ASCII_A + n - 1));
    m = n - 27;
    return 128'({8'(ASCII_A + m / 26), 8'(ASCII_A + m % 26)});
  endfunction

  function automatic logic [7:0] gen_len(input int n);
    if (n <= 0)  return 8'd0;
    if (n <= 26) return 8'd8;
    return 8'd16;
  endfunction

  // Generator advances on the edge where ready is high.
  always @(posedge clock) begin
    if (gen_rst)    gen_n <= 0;
    else if (ready) gen_n <= gen_n + 1;
  end
  always_comb begin
    candidate       = gen_word(gen_n);
    candidateLength = gen_len(gen_n);
  end

  always @(negedge clock) begin
    if (done)              done_cnt++;
    if (ready)             rdy_cnt++;
    if (ready && rdy_prev) rdy_wide++;
    rdy_prev = ready;
  end

  task automatic do_start(input logic [127:0] t, input logic [7:0] l);
    gen_rst = 1'b1; targetPassword = t; targetLength = l;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; gen_rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_attempts(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (attempts == 32'(n)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    nchk++; if ({enable, ready, busy, done} !== 4'b0) begin nfail++; $display("FAIL reset_ctl: got %b expected 0000", {enable, ready, busy, done}); end
    nchk++; if ({found, lengthError} !== 2'b0) begin nfail++; $display("FAIL reset_flags: got %b expected 00", {found, lengthError}); end
    nchk++; if (attempts !== 32'd0) begin nfail++; $display("FAIL reset_attempts: got %0d expected 0", attempts); end
    nchk++; if (matchPassword !== 128'd0) begin nfail++; $display("FAIL reset_match: got %0h expected 0", matchPassword); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_match_ab();
    bit ok; int d0;
    d0 = done_cnt;
    do_start(128'("ab"), 8'd16);
    wait_done(600, ok);
    nchk++; if (!ok) begin nfail++; $display("FAIL ab_timeout: got no done expected done"); end
    nchk++; if (found !== 1'b1) begin nfail++; $display("FAIL ab_found: got %b expected 1", found); end
    nchk++; if (matchPassword[15:0] !== 16'h6162) begin nfail++; $display("FAIL ab_match: got %h expected 6162", matchPassword[15:0]); end
    nchk++; if (attempts !== 32'd28) begin nfail++; $display("FAIL ab_attempts: got %0d expected 28", attempts); end
    repeat (3) @(negedge clock);
    nchk++; if (done_cnt - d0 !== 1) begin nfail++; $display("FAIL ab_done_once: got %0d expected 1", done_cnt - d0); end
    nchk++; if (enable !== 1'b0) begin nfail++; $display("FAIL ab_enable: got %b expected 0", enable); end
  endtask

  task automatic test_match_c();
    bit ok; int r0, w0;
    r0 = rdy_cnt; w0 = rdy_wide;
    do_start(128'("c"), 8'd8);
    targetPassword = 128'("x"); targetLength = 8'd16;
    wait_done(200, ok);
    nchk++; if (!ok) begin nfail++; $display("FAIL c_timeout: got no done expected done"); end
    nchk++; if (found !== 1'b1) begin nfail++; $display("FAIL c_found: got %b expected 1", found); end
    nchk++; if (attempts !== 32'd3) begin nfail++; $display("FAIL c_attempts: got %0d expected 3", attempts); end
    nchk++; if (matchPassword[7:0] !== 8'h63) begin nfail++; $display("FAIL c_match: got %h expected 63", matchPassword[7:0]); end
    repeat (2) @(negedge clock);
    nchk++; if (rdy_cnt - r0 !== 3) begin nfail++; $display("FAIL c_ready_count: got %0d expected 3", rdy_cnt - r0); end
    nchk++; if (rdy_wide - w0 !== 0) begin nfail++; $display("FAIL c_ready_width: got %0d expected 0", rdy_wide - w0); end
  endtask

  task automatic test_bad_length();
    int d0, r0;
    d0 = done_cnt; r0 = rdy_cnt;
    do_start(128'("ab"), 8'd12);
    nchk++; if ({enable, busy} !== 2'b10) begin nfail++; $display("FAIL len_checklen: got %b expected 10", {enable, busy}); end
    @(negedge clock);
    nchk++; if (done !== 1'b1) begin nfail++; $display("FAIL len_done: got %b expected 1", done); end
    nchk++; if (lengthError !== 1'b1) begin nfail++; $display("FAIL len_error: got %b expected 1", lengthError); end
    nchk++; if (found !== 1'b0) begin nfail++; $display("FAIL len_found: got %b expected 0", found); end
    nchk++; if (enable !== 1'b0) begin nfail++; $display("FAIL len_enable: got %b expected 0", enable); end
    repeat (2) @(negedge clock);
    nchk++; if (rdy_cnt - r0 !== 0) begin nfail++; $display("FAIL len_ready: got %0d expected 0", rdy_cnt - r0); end
    nchk++; if (done_cnt - d0 !== 1) begin nfail++; $display("FAIL len_done_once: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    bit ok; int d0;
    d0 = done_cnt;
    do_start(128'("~"), 8'd8);
    wait_attempts(5, 200, ok);
    nchk++; if (!ok) begin nfail++; $display("FAIL abort_timeout: got attempts %0d expected 5", attempts); end
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    nchk++; if ({enable, ready, busy} !== 3'b000) begin nfail++; $display("FAIL abort_ctl: got %b expected 000", {enable, ready, busy}); end
    nchk++; if (attempts !== 32'd5) begin nfail++; $display("FAIL abort_attempts: got %0d expected 5", attempts); end
    repeat (3) @(negedge clock);
    nchk++; if (done_cnt - d0 !== 0) begin nfail++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt - d0); end
    start = 1'b1; abort = 1'b1;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    @(negedge clock);
    nchk++; if (enable !== 1'b0) begin nfail++; $display("FAIL abort_wins_enable: got %b expected 0", enable); end
    nchk++; if (attempts !== 32'd5) begin nfail++; $display("FAIL abort_wins_attempts: got %0d expected 5", attempts); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_start(128'("zz"), 8'd16);
    wait_attempts(2, 100, ok);
    nchk++; if (!ok) begin nfail++; $display("FAIL arst_timeout: got attempts %0d expected 2", attempts); end
    #1 reset = 1'b1;
    #1;
    nchk++; if ({enable, ready, busy, done, found, lengthError} !== 6'b0) begin nfail++; $display("FAIL arst_ctl: got %b expected 000000", {enable, ready, busy, done, found, lengthError}); end
    nchk++; if (attempts !== 32'd0) begin nfail++; $display("FAIL arst_attempts: got %0d expected 0", attempts); end
    @(negedge clock); reset = 1'b0;
    do_start(128'("b"), 8'd8);
    wait_done(100, ok);
    nchk++; if (!ok || found !== 1'b1) begin nfail++; $display("FAIL arst_restart_found: got %b expected 1", found); end
    nchk++; if (attempts !== 32'd2) begin nfail++; $display("FAIL arst_restart_attempts: got %0d expected 2", attempts); end
  endtask

`ifdef ATTEMPT_LIMIT_EN
  task automatic test_limit();
    bit ok;
    maxAttempts = 32'd4;
    do_start(128'("~"), 8'd8);
    wait_done(200, ok);
    nchk++; if (!ok) begin nfail++; $display("FAIL limit_timeout: got no done expected done"); end
    nchk++; if (found !== 1'b0) begin nfail++; $display("FAIL limit_found: got %b expected 0", found); end
    nchk++; if (attempts !== 32'd4) begin nfail++; $display("FAIL limit_attempts: got %0d expected 4", attempts); end
    nchk++; if (lengthError !== 1'b0) begin nfail++; $display("FAIL limit_lenerr: got %b expected 0", lengthError); end
    maxAttempts = 32'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_match_ab();
    test_match_c();
    test_bad_length();
    test_abort();
    test_async_reset();
`ifdef ATTEMPT_LIMIT_EN
    test_limit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
